hash_result_serializer: RTL
===========================

// Module: hash_result_serializer
// PURPOSE
// Receive end of the test core's 16-bit Avalon-ST output stream.
// Buffers result words in a small FIFO and serializes each word into two
// 8-bit Avalon-ST beats, high byte first, toward the byte-wide host link.
// Reports a per-packet byte count and a completion pulse to management.
// PARAMETERS
// DEPTH    4   FIFO depth in 16-bit words; power of two, >= 2
// COUNT_W  16  width of packet byte counter / pkt_bytes
// PORTS
// clk                input   1        single clock, all logic rising-edge
// reset_n            input   1        asynchronous, active-low reset
// in_data            input   16       sink word
// in_valid           input   1        sink word valid
// in_ready           output  1        sink ready (= FIFO not full)
// in_startofpacket   input   1        word is first of packet
// in_endofpacket     input   1        word is last of packet
// out_data           output  8        source byte
// out_valid          output  1        source byte valid
// out_ready          input   1        downstream ready
// out_startofpacket  output  1        byte is first of packet
// out_endofpacket    output  1        byte is last of packet
// pkt_done           output  1        1-cycle pulse: packet fully sent
// pkt_bytes          output  COUNT_W  byte count of last completed packet
// BEHAVIOUR
// Reset (async assert, sync release): FIFO empty, state IDLE, byte count 0.
//   Outputs: in_ready=0 while reset_n=0, then 1; out_valid=0; out_data=0;
//   out_startofpacket=0; out_endofpacket=0; pkt_done=0; pkt_bytes=0.
// Sink: word accepted when in_valid && in_ready. FIFO entry = {sop,eop,data}.
//   in_ready is registered-free: in_ready = !full. No write when full, even
//   if a pop occurs in the same cycle (no pass-through).
// Source is zero-latency on ready: a beat transfers when out_valid && out_ready.
//   out_valid/out_data/sop/eop are held stable until the beat transfers.
// FSM:
//   IDLE: out_valid=0. FIFO non-empty -> HI.
//   HI: out_data=head[15:8], out_sop=head.sop, out_eop=0.
//       Beat transfers -> LO.
//   LO: out_data=head[7:0], out_sop=0, out_eop=head.eop.
//       Beat transfers -> pop head. Next state is HI if FIFO is still
//       non-empty after the pop, else IDLE.
// Latency: word accepted at edge N -> HI byte valid after edge N (cycle
//   N+1) when FIFO was empty; 2 bytes per word max, 1 byte/cycle.
// Simultaneous push and pop: both occur; occupancy unchanged. Pointers wrap
//   modulo DEPTH; occupancy counter 0..DEPTH distinguishes full from empty.
// Byte counter: +1 per transferred beat. Saturates at 2^COUNT_W-1.
//   On an eop beat transfer: pkt_bytes <= count+1 (saturated).
//   pkt_done=1 on the next cycle. Counter cleared to 0.
// sop on a word mid-packet does not clear the counter. Only eop and reset
//   delimit packets. Missing sop is not an error.
// Reset mid-packet: FIFO contents and partial count discarded, no pkt_done.
// out_ready low: FSM holds state; FIFO keeps filling; in_ready drops at full.
// TESTING
// 1 Send 4949(sop), b5de, 9600(eop), out_ready=1 -> bytes
//   49(sop),49,b5,de,96,00(eop), pkt_done 1 cycle, pkt_bytes=6.
// 2 out_ready=0, push 5 words -> 4 accepted, then in_ready=0.
//   Raise out_ready -> 10 bytes in order, no loss or duplicates.
// 3 Toggle out_ready every cycle during test 1 -> data held stable while
//   stalled; same 6 bytes; pkt_bytes=6.
// 4 Single word 1234 with sop+eop -> 12(sop), 34(eop), pkt_bytes=2.
// 5 Continuous stream, eop every 3 words, 50 packets across pointer wrap ->
//   50 pkt_done pulses, each pkt_bytes=6.
// 6 Assert reset_n=0 after first byte of test 1 -> all outputs at reset
//   values, no pkt_done. Rerun test 1 -> pkt_bytes=6.

Source files
------------

// File: rtl/hash_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : hash_result_serializer
// Description : Buffers 16-bit result words in a small FIFO and streams each
//               word out as two Avalon-ST byte beats (high byte first), with
//               a per-packet byte count and completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module hash_result_serializer #(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic [15:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,

    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_startofpacket,
    output logic               out_endofpacket,

    output logic               pkt_done,
    output logic [COUNT_W-1:0] pkt_bytes
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_OCC_W   = $clog2(DEPTH + 1);
    localparam int                 c_ENTRY_W = 18;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE = c_OCC_W'(1);
    localparam logic [c_OCC_W-1:0] c_OCC_MAX = c_OCC_W'(DEPTH);
    localparam logic [COUNT_W-1:0] c_CNT_ONE = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } state_t;

    // FIFO entry layout: {sop, eop, data[15:0]}
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_OCC_W-1:0]   r_occ;

    state_t               r_state;
    logic                 r_out_valid;
    logic [7:0]           r_out_data;
    logic                 r_out_sop;
    logic                 r_out_eop;

    logic [COUNT_W-1:0]   r_cnt;
    logic [COUNT_W-1:0]   r_pkt_bytes;
    logic                 r_pkt_done;

    logic                 w_full;
    logic                 w_push;
    logic                 w_beat;
    logic                 w_pop;
    logic [c_OCC_W-1:0]   w_occ_next;
    logic [c_ENTRY_W-1:0] w_in_entry;
    logic [c_ENTRY_W-1:0] w_head;
    logic [c_ENTRY_W-1:0] w_follow;
    logic [COUNT_W-1:0]   w_cnt_inc;

    assign w_full     = (r_occ == c_OCC_MAX);
    assign in_ready   = reset_n & ~w_full;
    assign w_push     = in_valid & in_ready;
    assign w_beat     = r_out_valid & out_ready;
    assign w_pop      = w_beat & (r_state == ST_LO);
    assign w_in_entry = {in_startofpacket, in_endofpacket, in_data};
    assign w_head     = r_mem[r_rd_ptr];

    // Word that becomes head after a pop: the next stored entry, or the word
    // being written this cycle when the head was the only one stored.
    assign w_follow   = (r_occ > c_OCC_ONE) ? r_mem[r_rd_ptr + c_PTR_ONE] : w_in_entry;

    assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

    always_comb begin
        w_occ_next = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + c_OCC_ONE;
            2'b01:   w_occ_next = r_occ - c_OCC_ONE;
            default: w_occ_next = r_occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_occ <= w_occ_next;
        end
    end

    // IDLE is only ever occupied with an empty FIFO, so a push seen in IDLE
    // is the new head and its high byte can be presented directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_push) begin
                        r_state     <= ST_HI;
                        r_out_valid <= 1'b1;
                        r_out_data  <= in_data[15:8];
                        r_out_sop   <= in_startofpacket;
                        r_out_eop   <= 1'b0;
                    end
                end
                ST_HI: begin
                    if (w_beat) begin
                        r_state    <= ST_LO;
                        r_out_data <= w_head[7:0];
                        r_out_sop  <= 1'b0;
                        r_out_eop  <= w_head[16];
                    end
                end
                ST_LO: begin
                    if (w_beat) begin
                        if (w_occ_next != '0) begin
                            r_state    <= ST_HI;
                            r_out_data <= w_follow[15:8];
                            r_out_sop  <= w_follow[17];
                            r_out_eop  <= 1'b0;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_sop   <= 1'b0;
                            r_out_eop   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_out_sop   <= 1'b0;
                    r_out_eop   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_pkt_bytes <= '0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            if (w_beat) begin
                if (r_out_eop) begin
                    r_pkt_bytes <= w_cnt_inc;
                    r_pkt_done  <= 1'b1;
                    r_cnt       <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign pkt_done          = r_pkt_done;
    assign pkt_bytes         = r_pkt_bytes;

endmodule
`default_nettype wire
